// File: rtl/vram_pkg.sv
// Shared video-RAM definitions: port widths, screen window and the packed
// write entry used between the CPU snoop queue and the VRAM arbiter.
package vram_pkg;

    localparam int VRAM_AW = 14;
    localparam int VRAM_DW = 16;

    localparam logic [15:0] SCREEN_BASE  = 16'h4000;
    localparam int          SCREEN_WORDS = 8192;

    typedef struct packed {
        logic [VRAM_AW-1:0] addr;
        logic [VRAM_DW-1:0] data;
    } vram_wr_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth. Pushes while full and pops while
// empty are ignored, so callers may drive push/pop without extra gating.
module sync_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vram_write_queue.sv
// Snoops CPU writes, keeps those inside the screen window and drains them one
// at a time into the VRAM arbiter write port.
module vram_write_queue #(
    parameter int          DEPTH        = 4,
    parameter logic [15:0] SCREEN_BASE  = vram_pkg::SCREEN_BASE,
    parameter int          SCREEN_WORDS = vram_pkg::SCREEN_WORDS
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         cpu_we,
    input  logic [14:0]                  cpu_addr,
    input  logic [15:0]                  cpu_data,
    output logic                         cpu_ready,
    output logic                         wren,
    output logic [vram_pkg::VRAM_AW-1:0] waddr,
    output logic [vram_pkg::VRAM_DW-1:0] wdata,
    input  logic                         wrack,
    output logic                         idle,
    output logic                         overflow
);

    localparam int unsigned WIN_LO = 32'(SCREEN_BASE);
    localparam int unsigned WIN_HI = WIN_LO + 32'(SCREEN_WORDS);

    vram_pkg::vram_wr_t                  entry_in;
    vram_pkg::vram_wr_t                  head;
    logic                                in_window;
    logic                                fifo_full;
    logic                                fifo_empty;
    logic                                push;
    logic [vram_pkg::VRAM_AW-1:0]        rebased;

    assign in_window = (32'(cpu_addr) >= WIN_LO) && (32'(cpu_addr) < WIN_HI);
    assign rebased   = cpu_addr[vram_pkg::VRAM_AW-1:0] - SCREEN_BASE[vram_pkg::VRAM_AW-1:0];
    assign entry_in  = '{addr: rebased, data: cpu_data};
    assign push      = cpu_we && in_window && !fifo_full;

    sync_fifo #(
        .WIDTH ($bits(vram_pkg::vram_wr_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (entry_in),
        .pop    (wrack),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (head)
    );

    // Handshake: wren is "valid" for the head entry and wrack is a one-cycle
    // "taken" pulse; the head pops on wrack, and wren drops in that same cycle
    // so the arbiter never sees the consumed entry requested twice.
    assign wren      = !fifo_empty && !wrack;
    assign waddr     = fifo_empty ? '0 : head.addr;
    assign wdata     = fifo_empty ? '0 : head.data;
    assign cpu_ready = !fifo_full;
    assign idle      = fifo_empty;

    // A same-cycle pop does not rescue a write that arrives while full.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (cpu_we && in_window && fifo_full) begin
            overflow <= 1'b1;
        end
    end

endmodule
